// File: rtl/sr_iter.sv
// sr_iter: iterative right shifter (SRL/SRA) for the multicycle ALU path.
// It shifts right by up to STEP bits per clock instead of using a full-width barrel shifter.
// A valid/ready handshake on each side means only one operation is in flight at a time.
//
// Ports
//   clock          single clock, all state updates on posedge
//   reset_n        asynchronous active-low reset
//   in_valid       request present on data_operandA/ctrl_shiftamt/ctrl_arith
//   in_ready       block can accept a request (IDLE only)
//   data_operandA  operand to shift
//   ctrl_shiftamt  right-shift amount
//   ctrl_arith     1 = sign fill, 0 = zero fill
//   out_valid      data_result is valid (DONE only)
//   out_ready      consumer accepts data_result
//   data_result    shifted result; keeps its last value until the next accept
module sr_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic               ctrl_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHAMT_W-1:0] STEP_V = SHAMT_W'(STEP);

  state_t                    state, state_nxt;
  logic signed [WIDTH-1:0]   shreg;
  logic                      fill;
  logic [SHAMT_W-1:0]        remaining;
  logic [SHAMT_W-1:0]        step_amt;
  logic [SHAMT_W-1:0]        rem_nxt;

  // Shift right by s (0..STEP) bits, filling vacated MSBs with f.
  function automatic logic signed [WIDTH-1:0] shift_fill(
    input logic signed [WIDTH-1:0] v,
    input logic [SHAMT_W-1:0]      s,
    input logic                    f
  );
    logic signed [WIDTH-1:0] r;
    r = v;
    for (int i = 0; i < STEP; i++) begin
      if (SHAMT_W'(i) < s) r = {f, r[WIDTH-1:1]};
    end
    return r;
  endfunction

  // The last step may be shorter than STEP when the remaining count is odd.
  assign step_amt = (remaining < STEP_V) ? remaining : STEP_V;
  assign rem_nxt  = remaining - step_amt;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign data_result = shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (ctrl_shiftamt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept / shift stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      fill      <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg     <= data_operandA;
            fill      <= ctrl_arith & data_operandA[WIDTH-1];
            remaining <= ctrl_shiftamt;
          end
        end
        SHIFT: begin
          shreg     <= shift_fill(shreg, step_amt, fill);
          remaining <= rem_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_iter.sv
// tb_sr_iter: randomized and directed bench for sr_iter.
// A latency/result model derived from plain shift arithmetic is checked every cycle.
// Directed cases pin the model with hand-computed literal results.
module tb_sr_iter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        ctrl_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;

  int checks = 0;
  int errors = 0;

  sr_iter #(.WIDTH(32), .SHAMT_W(5), .STEP(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .ctrl_arith    (ctrl_arith),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input int amt, input logic arith);
    if (arith) return 32'($signed(op) >>> amt);
    return op >> amt;
  endfunction

  // Behavioural model: 0 = idle, 1 = busy for ceil(amt/2) edges, 2 = result presented.
  int          m_st   = 0;
  int          m_left = 0;
  logic [31:0] m_res  = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_st   <= 0;
      m_left <= 0;
      m_res  <= '0;
    end else begin
      case (m_st)
        0: if (in_valid) begin
          m_res  <= ref_shift(data_operandA, int'(ctrl_shiftamt), ctrl_arith);
          m_left <= (int'(ctrl_shiftamt) + 1) / 2;
          m_st   <= (ctrl_shiftamt == 5'd0) ? 2 : 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_st <= 2;
        end
        default: if (out_ready) m_st <= 0;
      endcase
    end
  end

  always @(negedge clock) begin
    check("model_in_ready", {31'd0, in_ready}, {31'd0, m_st == 0});
    check("model_out_valid", {31'd0, out_valid}, {31'd0, m_st == 2});
    if (m_st != 1) check("model_result", data_result, m_res);
  end

  // Issue one request at the current (post-edge) time and follow it to completion.
  task automatic do_op(input logic [31:0] op, input logic [4:0] amt, input logic arith,
                       input int hold, input bit noise, input logic [31:0] exp, input int exp_lat);
    int lat;
    in_valid      = 1'b1;
    data_operandA = op;
    ctrl_shiftamt = amt;
    ctrl_arith    = arith;
    out_ready     = (hold == 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (noise) begin
        in_valid      = 1'($urandom_range(0, 1));
        data_operandA = $urandom;
        ctrl_shiftamt = 5'($urandom_range(0, 31));
        ctrl_arith    = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("result", data_result, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", data_result, exp);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("after_valid", {31'd0, out_valid}, 32'd0);
    check("after_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_result", data_result, exp);
    out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_arith    = 1'b0;
    out_ready     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", data_result, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed cases with hand-computed results
    do_op(32'h8000_0000, 5'd4, 1'b1, 0, 1'b0, 32'hF800_0000, 3);
    do_op(32'h8000_0000, 5'd31, 1'b0, 0, 1'b0, 32'h0000_0001, 17);
    do_op(32'h8000_0000, 5'd31, 1'b1, 0, 1'b0, 32'hFFFF_FFFF, 17);
    do_op(32'h1234_5678, 5'd0, 1'b0, 0, 1'b0, 32'h1234_5678, 1);
    do_op(32'h1234_5678, 5'd0, 1'b1, 0, 1'b0, 32'h1234_5678, 1);
    do_op(32'h7FFF_FFF0, 5'd3, 1'b1, 5, 1'b0, 32'h0FFF_FFFE, 3);
    do_op(32'hFFFF_0000, 5'd8, 1'b0, 0, 1'b1, 32'h00FF_FF00, 5);
    do_op(32'hF000_0000, 5'd1, 1'b1, 1, 1'b1, 32'hF800_0000, 2);
    do_op(32'hF000_0000, 5'd2, 1'b0, 0, 1'b0, 32'h3C00_0000, 2);
    check("model_pin", ref_shift(32'h8000_0000, 4, 1'b1), 32'hF800_0000);
    check("model_pin_srl", ref_shift(32'hFFFF_0000, 8, 1'b0), 32'h00FF_FF00);

    // Reset in the middle of a shift
    in_valid      = 1'b1;
    data_operandA = 32'h8000_0000;
    ctrl_shiftamt = 5'd20;
    ctrl_arith    = 1'b1;
    out_ready     = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result", data_result, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_op(32'hA5A5_0000, 5'd20, 1'b1, 0, 1'b0, 32'hFFFF_FA5A, 11);

    // Randomized operations
    for (int n = 0; n < 80; n++) begin
      logic [31:0] op;
      logic [4:0]  amt;
      logic        ar;
      op  = $urandom;
      amt = 5'($urandom_range(0, 31));
      ar  = 1'($urandom_range(0, 1));
      do_op(op, amt, ar, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            ref_shift(op, int'(amt), ar), 1 + (int'(amt) + 1) / 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
